// File: rtl/conv_result_serializer.sv
// conv_result_serializer: buffers POF-wide convolution results and
// drains them as rescaled, saturated single-filter valid/ready beats.
module conv_result_serializer #(
    parameter int POF          = 4,
    parameter int RESULT_WIDTH = 33,
    parameter int OUT_WIDTH    = 16,
    parameter int FRAC_SHIFT   = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_LEN_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [FRAME_LEN_W-1:0]       frame_len,
    input  logic                         in_valid,
    input  logic [POF*RESULT_WIDTH-1:0]  in_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [OUT_WIDTH-1:0]         m_data,
    output logic [$clog2(POF)-1:0]       m_filter,
    output logic                         m_last,
    output logic                         frame_done,
    output logic                         overflow,
    output logic                         busy
);

    localparam int FW = $clog2(POF);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int VW = POF * RESULT_WIDTH;
    localparam int GW = RESULT_WIDTH - OUT_WIDTH + 1;

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [FW-1:0] FLT_ONE = FW'(1);
    localparam logic [FW-1:0] FLT_LAST = FW'(POF - 1);
    localparam logic [FRAME_LEN_W-1:0] LEN_ONE =
        FRAME_LEN_W'(1);

    localparam logic signed [RESULT_WIDTH-1:0] SAT_MAX =
        {{GW{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RESULT_WIDTH-1:0] SAT_MIN =
        {{GW{1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_EMIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [VW-1:0]            r_mem [FIFO_DEPTH];
    logic [AW:0]              r_wptr;
    logic [AW:0]              r_rptr;

    logic [VW-1:0]            r_vec;
    logic [FW-1:0]            r_filter;
    logic [FRAME_LEN_W-1:0]   r_vcnt;
    logic [FRAME_LEN_W-1:0]   r_flen;
    logic                     r_ovf;
    logic                     r_done;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_push;
    logic                     w_wr;
    logic                     w_drop;
    logic                     w_pop;
    logic                     w_done;
    logic                     w_hs;
    logic                     w_last_filt;
    logic                     w_last_vec;
    logic [FRAME_LEN_W-1:0]   w_flen;

    logic signed [RESULT_WIDTH-1:0] w_lane [POF];
    logic signed [RESULT_WIDTH-1:0] w_sel;
    logic signed [RESULT_WIDTH-1:0] w_shift;
    logic [OUT_WIDTH-1:0]           w_sat;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // Vectors arriving outside a frame or alongside start are discarded.
    assign w_push = in_valid && !start && (r_state != S_IDLE);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    assign w_hs        = (r_state == S_EMIT) && m_ready;
    assign w_last_filt = (r_filter == FLT_LAST);
    assign w_last_vec  = (r_vcnt == (r_flen - LEN_ONE));
    assign w_flen      = (frame_len == '0) ? LEN_ONE : frame_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_done = 1'b0;
        if (start) begin
            w_next = S_RUN;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_next = S_IDLE;
                end
                S_RUN: begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_hs && w_last_filt) begin
                        if (w_last_vec) begin
                            w_next = S_IDLE;
                            w_done = 1'b1;
                        end else if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_next = S_RUN;
                        end
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (start) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= in_data;
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec    <= '0;
            r_filter <= '0;
            r_vcnt   <= '0;
            r_flen   <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done;
            if (start) begin
                r_vec    <= '0;
                r_filter <= '0;
                r_vcnt   <= '0;
                r_flen   <= w_flen;
                r_ovf    <= 1'b0;
            end else begin
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
                if (w_pop) begin
                    r_vec    <= r_mem[r_rptr[AW-1:0]];
                    r_filter <= '0;
                end else if (w_hs) begin
                    r_filter <= r_filter + FLT_ONE;
                end
                if (w_hs && w_last_filt && !w_last_vec) begin
                    r_vcnt <= r_vcnt + LEN_ONE;
                end
            end
        end
    end

    for (genvar f = 0; f < POF; f++) begin : g_lane
        assign w_lane[f] =
            r_vec[f*RESULT_WIDTH +: RESULT_WIDTH];
    end

    assign w_sel   = w_lane[r_filter];
    assign w_shift = w_sel >>> FRAC_SHIFT;

    always_comb begin
        w_sat = w_shift[OUT_WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    assign m_valid    = (r_state == S_EMIT);
    assign m_data     = w_sat;
    assign m_filter   = r_filter;
    assign m_last     = m_valid && w_last_vec && w_last_filt;
    assign frame_done = r_done;
    assign overflow   = r_ovf;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/conv_result_serializer.md
Name: conv_result_serializer

Overview:
- Receiver/drain end of the convolution core's result interface.
- Captures each POF-wide result vector (output_valid_out / results_data_flat) into a small vector FIFO.
- Rescales and saturates each filter result from RESULT_WIDTH to OUT_WIDTH, then emits one filter result per beat on a valid/ready stream toward writeback.
- Counts vectors per frame, marks the last beat of the frame, and flags dropped vectors, since the core has no backpressure.

Parameters:
POF, 4, filters per result vector
RESULT_WIDTH, 33, signed width of each filter result
OUT_WIDTH, 16, signed width of each emitted beat
FRAC_SHIFT, 0, arithmetic right shift applied before saturation (0..RESULT_WIDTH-2)
FIFO_DEPTH, 4, vector FIFO entries (power of 2, >=2)
FRAME_LEN_W, 16, width of the frame_len input

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin a new frame, flush state
frame_len  input  FRAME_LEN_W  vectors expected this frame, sampled on start; 0 is treated as 1
in_valid  input  1  result vector present (driven by core output_valid_out)
in_data  input  POF*RESULT_WIDTH  flat vector, filter f at bits [(f+1)*RESULT_WIDTH-1 : f*RESULT_WIDTH]
m_valid  output  1  output beat valid
m_ready  input  1  downstream accepts beat
m_data  output  OUT_WIDTH  scaled, saturated signed result
m_filter  output  clog2(POF)  filter index of current beat
m_last  output  1  last beat of the frame
frame_done  output  1  one-cycle pulse after the m_last handshake
overflow  output  1  sticky: at least one vector dropped since start/reset
busy  output  1  frame active (start seen, frame_done not yet pulsed)

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; FIFO empty; FSM in IDLE; vector and filter counters 0.
  - Reset mid-frame discards all buffered data with no beat emitted.
- FIFO write:
  - Every cycle with in_valid=1, the vector is pushed.
  - If the FIFO is full and no pop happens in the same cycle, the vector is dropped and overflow is set.
  - Simultaneous push+pop when full is legal: no drop, occupancy unchanged.
- FSM:
  - IDLE: wait for start.
  - RUN: output register empty.
  - EMIT: output register holds a vector.
  - IDLE --start--> RUN.
  - RUN --FIFO non-empty--> EMIT. Pop the vector into the output register, m_filter=0, m_valid=1 next cycle.
  - EMIT: a beat completes when m_valid&m_ready; then m_filter increments.
  - On the handshake of filter POF-1: if it was the frame's last vector, go to IDLE and pulse frame_done next cycle. Otherwise, if the FIFO is non-empty, pop and stay in EMIT (back-to-back, no bubble); else go to RUN.
- Latency: in_valid at edge N into an empty FIFO in RUN gives m_valid high after edge N+2.
- Stability: m_data, m_filter, and m_last stay stable while m_valid=1 and m_ready=0.
- Pushes while in IDLE are dropped silently; overflow is not set.
- Arithmetic:
  - s = result_f >>> FRAC_SHIFT (sign-preserving, floor).
  - m_data = clamp(s, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
- m_last = (vector count == frame_len-1) && (m_filter == POF-1).
- Vector counter wraps never: the frame ends at frame_len.
- start while busy: abort the frame, flush the FIFO, drop the output register (m_valid=0 next cycle), clear overflow and counters, re-sample frame_len, enter RUN.
- start and in_valid in the same cycle: the flush takes priority and the incoming vector is discarded.
- busy: 1 from the cycle after start until the cycle frame_done pulses.

Test Plan:
- All-ones 3x3 kernel, pixels=5, frame_len=78, FRAC_SHIFT=0, m_ready=1 -> 312 beats, all m_data=45; m_filter cycles 0,1,2,3; m_last only on beat 312; frame_done one cycle later.
- Saturation: in_data filters {70000, -70000, 32767, -32769}, FRAC_SHIFT=0 -> 32767, -32768, 32767, -32768. With FRAC_SHIFT=2, filter 0 = 70000 -> 17500 and -7 -> -2.
- Backpressure: m_ready toggled 1 cycle on / 3 off while 4 vectors arrive back-to-back -> no drops, overflow=0, 16 beats in order with data held stable during stalls.
- Overflow: m_ready=0, 6 consecutive in_valid with FIFO_DEPTH=4 -> 5 vectors retained (4 FIFO + 1 output register); overflow=1 from the cycle after the 6th push; after releasing m_ready, exactly 20 beats.
- start issued mid-frame with 2 vectors buffered -> m_valid=0 next cycle, overflow cleared, the new frame of frame_len=1 emits exactly 4 beats then frame_done.
- rst_n asserted low mid-EMIT -> all outputs 0 immediately (asynchronously); after release and start, normal operation with no stale beats.
